// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, colour constants and fill-engine state encodings.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 160;
    localparam int unsigned FB_HEIGHT = 120;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned COLOR_W   = 24;
    localparam int unsigned FB_SIZE   = FB_WIDTH * FB_HEIGHT;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = 24'h000000;
    localparam logic [COLOR_W-1:0] COLOR_WHITE = 24'hFFFFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Rectangle request as latched at the accepting edge.
    typedef struct packed {
        logic [7:0]         x0;
        logic [6:0]         y0;
        logic [7:0]         w;
        logic [6:0]         h;
        logic [COLOR_W-1:0] color;
    } fill_req_t;

endpackage

// File: rtl/fb_row_base.sv
// Row start address y*FB_WIDTH as a shift-add (160 = 128 + 32); shared with point-write stages.
module fb_row_base
    import fb_pkg::*;
(
    input  logic [6:0]        y_i,
    output logic [ADDR_W-1:0] base_o
);

    assign base_o = (ADDR_W'(y_i) << 7) + (ADDR_W'(y_i) << 5);

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle-fill engine: accepts one clipped rectangle and streams one
// frame-buffer pixel write per cycle in raster order.
module rect_fill_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         x0,
    input  logic [6:0]         y0,
    input  logic [7:0]         w,
    input  logic [6:0]         h,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               wr_en
);

    localparam logic [8:0]        X_LIM   = 9'(FB_WIDTH);
    localparam logic [7:0]        Y_LIM   = 8'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(FB_WIDTH);

    logic [1:0]         state_q, state_d;
    fill_req_t          req_q, req_d;
    logic [8:0]         x_end_q, x_end_d;
    logic [7:0]         y_end_q, y_end_d;
    logic [7:0]         col_q, col_d;
    logic [6:0]         row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;

    logic [ADDR_W-1:0]  first_row_base;
    logic [ADDR_W-1:0]  next_row_base;
    logic [8:0]         x_sum, x_clip;
    logic [7:0]         y_sum, y_clip;
    logic               req_empty;
    logic               last_col, last_row;

    fb_row_base u_row_base (
        .y_i    (req_q.y0),
        .base_o (first_row_base)
    );

    // Clipping arithmetic is one bit wider than the operands so sums never wrap.
    always_comb begin
        x_sum     = {1'b0, req_q.x0} + {1'b0, req_q.w};
        y_sum     = {1'b0, req_q.y0} + {1'b0, req_q.h};
        x_clip    = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_clip    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        req_empty = (req_q.w == 8'd0) || (req_q.h == 7'd0) ||
                    ({1'b0, req_q.x0} >= X_LIM) || ({1'b0, req_q.y0} >= Y_LIM);
    end

    always_comb begin
        last_col      = ({1'b0, col_q} == (x_end_q - 9'd1));
        last_row      = ({1'b0, row_q} == (y_end_q - 8'd1));
        next_row_base = row_base_q + ROW_INC;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    req_d.x0    = x0;
                    req_d.y0    = y0;
                    req_d.w     = w;
                    req_d.h     = h;
                    req_d.color = color;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                x_end_d = x_clip;
                y_end_d = y_clip;
                if (req_empty) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    col_d      = req_q.x0;
                    row_d      = req_q.y0;
                    row_base_d = first_row_base;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = first_row_base + ADDR_W'(req_q.x0);
                    wr_data_d  = req_q.color;
                    state_d    = ST_FILL;
                end
            end

            // The registered write on the bus is pixel (col_q, row_q); stage the next one.
            ST_FILL: begin
                if (last_col && last_row) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (last_col) begin
                    col_d      = req_q.x0;
                    row_d      = row_q + 7'd1;
                    row_base_d = next_row_base;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = next_row_base + ADDR_W'(req_q.x0);
                end else begin
                    col_d     = col_q + 8'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base_q + ADDR_W'(col_q) + ADDR_W'(1);
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
